alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit operating alongside the single-cycle ALU in the execute stage. It replaces the fixed 18x18 and stretched-clock 32x32 multiply paths with a multi-cycle shift-add multiplier and restoring divider of configurable width. The unit has a start/valid handshake and a busy flag, and the pipeline stalls on busy. It produces the low product, the high product, the quotient or the remainder, with overflow and divide-by-zero flags.

---
 rtl/alu_muldiv_if.sv | 27 ++
 rtl/alu_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Handshake and data bundle for the iterative multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [1:0]       op;
    logic             sgn;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic             dzout;

    modport master (
        output start, kill, op, sgn, din_a, din_b,
        input  busy, valid, dout, vout, dzout
    );

    modport slave (
        input  start, kill, op, sgn, din_a, din_b,
        output busy, valid, dout, vout, dzout
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// op: 00 MUL low half, 01 MULH high half, 10 DIV quotient, 11 MOD remainder.
// Optional build macro MULDIV_SIGNED_EN enables signed operation via sgn;
// without it sgn is ignored and everything is unsigned.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset_b,
    alu_muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic [1:0]           op_r;
    logic                 sgn_r;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 ovf_case;
    logic                 dz_r;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     b_r;

    logic                 sgn_eff;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 accept;
    logic                 div_zero;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_r2;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     res;
    logic                 res_v;
    logic                 res_dz;

`ifdef MULDIV_SIGNED_EN
    assign sgn_eff = bus.sgn;
    assign a_mag   = (sgn_eff && bus.din_a[WIDTH-1]) ? -bus.din_a : bus.din_a;
    assign b_mag   = (sgn_eff && bus.din_b[WIDTH-1]) ? -bus.din_b : bus.din_b;
`else
    logic unused_sign;
    assign unused_sign = bus.sgn ^ neg_res ^ neg_rem;
    assign sgn_eff     = 1'b0;
    assign a_mag       = bus.din_a;
    assign b_mag       = bus.din_b;
`endif

    assign accept   = (state == IDLE) && bus.start && !bus.kill;
    assign div_zero = bus.op[1] && (bus.din_b == '0);
    assign bus.busy  = (state != IDLE);
    assign bus.valid = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill overrides everything, divide-by-zero skips RUN
    // but still passes through FIX so the result is formed in one place.
    always_comb begin
        state_next = state;
        if (bus.kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = div_zero ? FIX : RUN;
                RUN:     if (count == '0) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // One iteration step: multiply uses acc = {partial, multiplier},
    // divide uses acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_r2   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_r2[WIDTH-1:0] - b_r;
        if (div_r2 >= {1'b0, b_r}) begin
            div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_r2[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction, result select and flags, consumed in FIX
    always_comb begin
        prod = acc;
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_res) begin
            prod = -acc;
            quot = -acc[WIDTH-1:0];
        end
        if (neg_rem) begin
            rem = -acc[2*WIDTH-1:WIDTH];
        end
`endif
        res    = '0;
        res_v  = 1'b0;
        res_dz = 1'b0;
        if (dz_r) begin
            res    = op_r[0] ? acc[WIDTH-1:0] : '1;
            res_dz = 1'b1;
        end else begin
            case (op_r)
                2'b00: begin
                    res   = prod[WIDTH-1:0];
                    res_v = sgn_r ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                  : (prod[2*WIDTH-1:WIDTH] != '0);
                end
                2'b01: res = prod[2*WIDTH-1:WIDTH];
                2'b10: begin
                    res   = quot;
                    res_v = ovf_case;
                end
                default: begin
                    res   = rem;
                    res_v = ovf_case;
                end
            endcase
        end
    end

    // Operand capture, iteration and output registers
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            count     <= '0;
            op_r      <= '0;
            sgn_r     <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            ovf_case  <= 1'b0;
            dz_r      <= 1'b0;
            acc       <= '0;
            b_r       <= '0;
            bus.dout  <= '0;
            bus.vout  <= 1'b0;
            bus.dzout <= 1'b0;
        end else begin
            if (accept) begin
                op_r     <= bus.op;
                sgn_r    <= sgn_eff;
                count    <= CW'(WIDTH - 1);
                dz_r     <= div_zero;
                neg_res  <= sgn_eff && (bus.din_a[WIDTH-1] ^ bus.din_b[WIDTH-1]);
                neg_rem  <= sgn_eff && bus.din_a[WIDTH-1];
                ovf_case <= sgn_eff && bus.op[1]
                            && (bus.din_a == {1'b1, {(WIDTH-1){1'b0}}})
                            && (bus.din_b == '1);
                b_r      <= b_mag;
                acc      <= {{WIDTH{1'b0}}, (div_zero ? bus.din_a : a_mag)};
            end else if (state == RUN) begin
                acc <= op_r[1] ? div_next : mul_next;
                if (count != '0) begin
                    count <= count - 1'b1;
                end
            end
            if ((state == FIX) && !bus.kill) begin
                bus.dout  <= res;
                bus.vout  <= res_v;
                bus.dzout <= res_dz;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at WIDTH=32: directed vector table,
// randomized operations against an arithmetic reference model, and
// kill / reset / start-while-busy sequences.
module tb_alu_muldiv;
    localparam int unsigned W = 32;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(W)) bus ();
    alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset_b(reset_b), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        v;
        logic        z;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input logic [1:0] op, input logic s, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] d, input logic v,
                                    input logic z, input int lat);
        vec_t t;
        t.op = op; t.s = s; t.a = a; t.b = b; t.d = d; t.v = v; t.z = z; t.lat = lat;
        vecs.push_back(t);
    endfunction

    // Reference: native 64-bit / 32-bit arithmetic following the operation rules
    function automatic void model(input logic [1:0] op, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] d,
                                  output logic v, output logic z);
        logic        sg;
        logic [63:0] p;
        int          sa, sb;
        int unsigned ua, ub;
        sg = s && SIGNED_EN;
        d = '0; v = 1'b0; z = 1'b0;
        if (op[1] && b == 32'h0) begin
            z = 1'b1;
            d = op[0] ? a : 32'hFFFF_FFFF;
        end else if (!op[1]) begin
            if (sg) p = longint'($signed(a)) * longint'($signed(b));
            else    p = longint'({32'h0, a}) * longint'({32'h0, b});
            if (op[0]) begin
                d = p[63:32];
            end else begin
                d = p[31:0];
                v = sg ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'h0);
            end
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                d = op[0] ? 32'h0 : 32'h8000_0000;
                v = 1'b1;
            end else begin
                sa = a; sb = b;
                d = op[0] ? 32'(sa % sb) : 32'(sa / sb);
            end
        end else begin
            ua = a; ub = b;
            d = op[0] ? (ua % ub) : (ua / ub);
        end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] d, output logic v,
                          output logic z, output int lat);
        bus.op = op; bus.sgn = s; bus.din_a = a; bus.din_b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_accept", {63'h0, bus.busy}, 64'd1);
        lat = 0;
        while (!bus.valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.valid) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: got no valid within %0d cycles, required a pulse", lat);
        end
        d = bus.dout; v = bus.vout; z = bus.dzout;
        tick();
        check("valid_single_cycle", {63'h0, bus.valid}, 64'd0);
        check("busy_drops", {63'h0, bus.busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] d, ed, prev, a, b, bd;
        logic        v, z, ev, ez;
        logic [1:0]  op;
        logic        s;
        int          lat, nv, vat;

        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'b00; bus.sgn = 1'b0;
        bus.din_a = '0; bus.din_b = '0;
        reset_b = 1'b0;
        repeat (3) tick();
        reset_b = 1'b1;
        tick();
        check("rst_busy", {63'h0, bus.busy}, 64'd0);
        check("rst_valid", {63'h0, bus.valid}, 64'd0);
        check("rst_dout", {32'h0, bus.dout}, 64'd0);
        check("rst_vout", {63'h0, bus.vout}, 64'd0);
        check("rst_dzout", {63'h0, bus.dzout}, 64'd0);

        // Directed vectors with hand-derived expectations
        add_vec(2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b0, 33);
        add_vec(2'b01, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0, 33);
        add_vec(2'b10, 1'b0, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33);
        add_vec(2'b11, 1'b0, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33);
        add_vec(2'b10, 1'b0, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1);
        add_vec(2'b11, 1'b0, 32'h0000_1234, 32'h0,         32'h0000_1234, 1'b0, 1'b1, 1);
        add_vec(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 33);
        add_vec(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        add_vec(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        add_vec(2'b11, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 33);
        add_vec(2'b10, 1'b0, 32'd5,         32'd9,         32'd0,         1'b0, 1'b0, 33);
        add_vec(2'b11, 1'b0, 32'd5,         32'd9,         32'd5,         1'b0, 1'b0, 33);
`ifdef MULDIV_SIGNED_EN
        add_vec(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 33);
        add_vec(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
        add_vec(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 33);
        add_vec(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 33);
        add_vec(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, 1'b0, 33);
        add_vec(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0, 33);
`else
        add_vec(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0, 1'b0, 33);
        add_vec(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 1'b0, 1'b0, 33);
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b, d, v, z, lat);
            check($sformatf("vec%0d_dout", i), {32'h0, d}, {32'h0, vecs[i].d});
            check($sformatf("vec%0d_vout", i), {63'h0, v}, {63'h0, vecs[i].v});
            check($sformatf("vec%0d_dzout", i), {63'h0, z}, {63'h0, vecs[i].z});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom & 32'h0000_FFFF;
                default: b = $urandom;
            endcase
            model(op, s, a, b, ed, ev, ez);
            run_op(op, s, a, b, d, v, z, lat);
            check($sformatf("rnd%0d_dout", i), {32'h0, d}, {32'h0, ed});
            check($sformatf("rnd%0d_vout", i), {63'h0, v}, {63'h0, ev});
            check($sformatf("rnd%0d_dzout", i), {63'h0, z}, {63'h0, ez});
            check($sformatf("rnd%0d_latency", i), 64'(lat), ez ? 64'd1 : 64'd33);
        end

        // Kill in RUN cycle 10 together with a new start
        run_op(2'b00, 1'b0, 32'd1234, 32'd5678, d, v, z, lat);
        prev = bus.dout;
        bus.op = 2'b10; bus.sgn = 1'b0; bus.din_a = 32'd1000; bus.din_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.kill = 1'b1; bus.start = 1'b1; bus.din_a = 32'd77; bus.din_b = 32'd5;
        tick();
        bus.kill = 1'b0; bus.start = 1'b0;
        check("kill_busy", {63'h0, bus.busy}, 64'd0);
        check("kill_valid", {63'h0, bus.valid}, 64'd0);
        check("kill_dout_held", {32'h0, bus.dout}, {32'h0, prev});
        nv = 0;
        repeat (40) begin
            tick();
            if (bus.valid) nv++;
        end
        check("kill_no_pulse", 64'(nv), 64'd0);

        // Reset in RUN cycle 10 after an op that left non-zero outputs
        run_op(2'b10, 1'b0, 32'h0000_1234, 32'h0, d, v, z, lat);
        bus.op = 2'b10; bus.din_a = 32'd1000; bus.din_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset_b = 1'b0; bus.start = 1'b1;
        tick();
        reset_b = 1'b1; bus.start = 1'b0;
        check("reset_busy", {63'h0, bus.busy}, 64'd0);
        check("reset_valid", {63'h0, bus.valid}, 64'd0);
        check("reset_dout", {32'h0, bus.dout}, 64'd0);
        check("reset_vout", {63'h0, bus.vout}, 64'd0);
        check("reset_dzout", {63'h0, bus.dzout}, 64'd0);
        nv = 0;
        repeat (40) begin
            tick();
            if (bus.valid) nv++;
        end
        check("reset_no_pulse", 64'(nv), 64'd0);

        // Start held during busy with different operands is ignored
        model(2'b00, 1'b0, 32'd1234, 32'd5678, ed, ev, ez);
        bus.op = 2'b00; bus.sgn = 1'b0; bus.din_a = 32'd1234; bus.din_b = 32'd5678; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op = 2'b11; bus.din_a = 32'd999; bus.din_b = 32'd10;
        nv = 0; vat = -1; bd = '0;
        for (int k = 0; k < 80; k++) begin
            if (bus.valid) begin
                nv++;
                vat = k;
                bd = bus.dout;
            end
            bus.start = (k >= 1 && k <= 33);
            tick();
        end
        bus.start = 1'b0;
        check("busy_start_pulses", 64'(nv), 64'd1);
        check("busy_start_cycle", 64'(vat), 64'd33);
        check("busy_start_dout", {32'h0, bd}, {32'h0, ed});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
